sipo_deser: RTL and testbench
=============================

SIPO_DESER -- requirements
Module: sipo_deser

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the number of bits per output word (legal range 2..32).
REQ-002 SHALL have parameter MSB_FIRST, default 1, meaning bit order: 1 = first received bit lands in o_data[WIDTH-1], 0 = first received bit lands in o_data[0].
REQ-003 SHALL have port i_clk  input  1  clock, with all state updated on its rising edge.
REQ-004 SHALL have port i_rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port i_d  input  1  serial data bit.
REQ-006 SHALL have port i_d_valid  input  1  i_d carries a valid bit this cycle.
REQ-007 SHALL have port o_d_ready  output  1  block accepts a serial bit this cycle.
REQ-008 SHALL have port i_flush  input  1  discard the partially or fully assembled word held in the shifter.
REQ-009 SHALL have port o_data  output  WIDTH  assembled parallel word, registered.
REQ-010 SHALL have port o_valid  output  1  o_data holds an unconsumed word.
REQ-011 SHALL have port i_ready  input  1  downstream consumes o_data this cycle when o_valid=1.
REQ-012 SHALL have port o_cnt  output  $clog2(WIDTH+1)  number of bits currently held in the shifter (0..WIDTH).

Function
REQ-013 SHALL define a bit accept as i_d_valid=1 and o_d_ready=1 at a rising edge, and a word drain as o_valid=1 and i_ready=1 at a rising edge.
REQ-014 SHALL implement a two-state FSM: COLLECT (o_d_ready=1) and STALL (o_d_ready=0, shifter holds a complete word).
REQ-015 SHALL, for MSB_FIRST=1, shift the shifter left on each accept with i_d entering bit 0, and for MSB_FIRST=0, shift it right with i_d entering bit WIDTH-1.
REQ-016 SHALL increment o_cnt by 1 on each accept that does not complete a word.
REQ-017 SHALL treat the holding register as free when o_valid=0 or a word drain occurs in the same cycle.
REQ-018 SHALL, on an accept with o_cnt=WIDTH-1 while the holding register is free, load the completed word into o_data, set o_valid=1 after that edge, set o_cnt to 0, and stay in COLLECT, giving a latency of 1 edge from the last bit to o_valid.
REQ-019 SHALL, on an accept with o_cnt=WIDTH-1 while the holding register is not free, move to STALL with o_cnt=WIDTH and keep o_data unchanged.
REQ-020 SHALL, in STALL on a word drain, load the shifter word into o_data, keep o_valid=1, set o_cnt to 0, and return to COLLECT.
REQ-021 SHALL clear o_valid on a word drain when no load occurs on the same edge.
REQ-022 SHALL, on a simultaneous drain and load, keep o_valid=1 and present the new word with no bubble.
REQ-023 SHALL, on i_flush=1, set o_cnt to 0 and enter COLLECT, discarding any bit accepted on that edge.
REQ-024 SHALL leave o_data and o_valid unaffected by i_flush.
REQ-025 SHALL make flush win over word completion when both occur on the same edge.
REQ-026 SHALL hold o_data stable while o_valid=1 and i_ready=0.
REQ-027 SHALL ignore i_d whenever i_d_valid=0 or o_d_ready=0.
REQ-028 SHALL sustain one bit per cycle indefinitely while i_ready=1, with no stall.

Reset
REQ-029 SHALL, while i_rst=1 at a rising edge, set o_data=0, o_valid=0, o_cnt=0, shifter=0, state=COLLECT, and hold o_d_ready=0 for as long as i_rst is high.
REQ-030 SHALL give i_rst priority over i_flush, accepts and drains, so that reset mid-word or in STALL discards all held data.
REQ-031 SHALL assert o_d_ready=1 in the first cycle after i_rst deasserts.

Verification
REQ-032 SHALL cover, with WIDTH=8, MSB_FIRST=1 and i_ready=1, bits 1,0,1,1,0,0,1,0 sent back-to-back -> o_valid=1 for one cycle after the 8th accept with o_data=8'hB2.
REQ-033 SHALL cover the same bits with MSB_FIRST=0 -> o_data=8'h4D.
REQ-034 SHALL cover i_ready=0 with bits for 8'hB2 then 8'h0F sent -> o_data=8'hB2, o_cnt=8, o_d_ready=0; then i_ready pulsed once -> o_data=8'h0F, o_valid stays 1, o_cnt=0, o_d_ready=1.
REQ-035 SHALL cover 24 continuous bits with i_ready=1 -> three single-cycle o_valid pulses 8 cycles apart and o_d_ready constantly 1.
REQ-036 SHALL cover i_flush asserted after 5 accepts -> o_cnt=0; the next 8 bits 1,1,1,1,0,0,0,0 -> o_data=8'hF0.
REQ-037 SHALL cover i_rst asserted after 3 accepts with o_valid=1 -> next cycle o_valid=0, o_data=0, o_cnt=0; a full word afterwards assembles correctly.

Source files
------------

// File: rtl/sipo_deser.sv
// Serial-in, parallel-out deserializer with a registered output word and
// backpressure: a full shifter stalls serial input until the output word drains.
module sipo_deser #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_d,
    input  logic                         i_d_valid,
    output logic                         o_d_ready,
    input  logic                         i_flush,
    output logic [WIDTH-1:0]             o_data,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic [$clog2(WIDTH+1)-1:0]   o_cnt
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);

    typedef enum logic {
        COLLECT = 1'b0,
        STALL   = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  shifter_q;
    logic [WIDTH-1:0]  shift_next;
    logic [WIDTH-1:0]  load_word;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  data_q;
    logic              valid_q, valid_d;
    logic              accept, drain, hold_free;
    logic              shift_en, load, load_from_stall;

    // Ready is forced low during reset so no bit can be accepted on a reset edge.
    assign o_d_ready = (state_q == COLLECT) && !i_rst;
    assign accept    = i_d_valid && o_d_ready;
    assign drain     = valid_q && i_ready;
    assign hold_free = !valid_q || drain;

    assign shift_next = MSB_FIRST ? {shifter_q[WIDTH-2:0], i_d}
                                  : {i_d, shifter_q[WIDTH-1:1]};
    assign load_word  = load_from_stall ? shifter_q : shift_next;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_d         = state_q;
        cnt_d           = cnt_q;
        shift_en        = 1'b0;
        load            = 1'b0;
        load_from_stall = 1'b0;

        if (i_flush) begin
            state_d = COLLECT;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                COLLECT: begin
                    if (accept) begin
                        if (cnt_q == CNT_LAST) begin
                            if (hold_free) begin
                                load  = 1'b1;
                                cnt_d = '0;
                            end else begin
                                shift_en = 1'b1;
                                cnt_d    = CNT_FULL;
                                state_d  = STALL;
                            end
                        end else begin
                            shift_en = 1'b1;
                            cnt_d    = cnt_q + CW'(1);
                        end
                    end
                end
                STALL: begin
                    if (drain) begin
                        load            = 1'b1;
                        load_from_stall = 1'b1;
                        cnt_d           = '0;
                        state_d         = COLLECT;
                    end
                end
                default: state_d = COLLECT;
            endcase
        end
    end

    // A load on the same edge as a drain keeps valid high: no bubble.
    assign valid_d = load ? 1'b1 : (drain ? 1'b0 : valid_q);

    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (i_rst) begin
            state_q   <= COLLECT;
            cnt_q     <= '0;
            shifter_q <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            if (shift_en) shifter_q <= shift_next;
            if (load)     data_q    <= load_word;
        end
    end

    assign o_data  = data_q;
    assign o_valid = valid_q;
    assign o_cnt   = cnt_q;

endmodule

// File: tb/tb_sipo_deser.sv
// Directed bench for sipo_deser: two instances (MSB-first and LSB-first) share
// stimulus; expected words are hand-computed from the transmitted bit order.
module tb_sipo_deser;

    logic       clk = 1'b0;
    logic       rst;
    logic       d;
    logic       d_valid;
    logic       flush;
    logic       ready;

    logic       d_ready_m, valid_m;
    logic [7:0] data_m;
    logic [3:0] cnt_m;
    logic       d_ready_l, valid_l;
    logic [7:0] data_l;
    logic [3:0] cnt_l;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    sipo_deser #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_d       (d),
        .i_d_valid (d_valid),
        .o_d_ready (d_ready_m),
        .i_flush   (flush),
        .o_data    (data_m),
        .o_valid   (valid_m),
        .i_ready   (ready),
        .o_cnt     (cnt_m)
    );

    sipo_deser #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_d       (d),
        .i_d_valid (d_valid),
        .o_d_ready (d_ready_l),
        .i_flush   (flush),
        .o_data    (data_l),
        .o_valid   (valid_l),
        .i_ready   (ready),
        .o_cnt     (cnt_l)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sends the top n bits of w, most significant first, with no gaps.
    task automatic send_bits(input logic [7:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            d       = w[7-i];
            d_valid = 1'b1;
            tick();
        end
    endtask

    logic [7:0] words [3];

    initial begin
        words[0] = 8'hA5;
        words[1] = 8'h3C;
        words[2] = 8'h81;

        rst = 1'b1; d = 1'b0; d_valid = 1'b0; flush = 1'b0; ready = 1'b1;
        tick();
        tick();
        check("rst_valid",   32'(valid_m),   32'h0);
        check("rst_data",    32'(data_m),    32'h0);
        check("rst_cnt",     32'(cnt_m),     32'h0);
        check("rst_d_ready", 32'(d_ready_m), 32'h0);
        rst = 1'b0;
        #1;
        check("post_rst_d_ready", 32'(d_ready_m), 32'h1);

        // Bits 1,0,1,1,0,0,1,0 back-to-back.
        send_bits(8'hB2, 7);
        check("b2_cnt7",    32'(cnt_m),   32'h7);
        check("b2_early_v", 32'(valid_m), 32'h0);
        d = 1'b0;
        tick();
        d_valid = 1'b0;
        check("b2_valid",  32'(valid_m), 32'h1);
        check("b2_data",   32'(data_m),  32'hB2);
        check("lsb_data",  32'(data_l),  32'h4D);
        check("b2_cnt0",   32'(cnt_m),   32'h0);
        tick();
        check("b2_pulse_end", 32'(valid_m), 32'h0);

        // Backpressure: second word stalls in the shifter.
        ready = 1'b0;
        send_bits(8'hB2, 8);
        d_valid = 1'b0;
        check("bp_first_valid", 32'(valid_m), 32'h1);
        send_bits(8'h0F, 8);
        d_valid = 1'b0;
        check("bp_stall_data",    32'(data_m),    32'hB2);
        check("bp_stall_cnt",     32'(cnt_m),     32'h8);
        check("bp_stall_d_ready", 32'(d_ready_m), 32'h0);
        d = 1'b1; d_valid = 1'b1;
        tick();
        d_valid = 1'b0;
        check("bp_hold_data", 32'(data_m), 32'hB2);
        check("bp_hold_cnt",  32'(cnt_m),  32'h8);
        ready = 1'b1;
        tick();
        check("bp_drain_data",    32'(data_m),    32'h0F);
        check("bp_drain_valid",   32'(valid_m),   32'h1);
        check("bp_drain_cnt",     32'(cnt_m),     32'h0);
        check("bp_drain_d_ready", 32'(d_ready_m), 32'h1);
        check("bp_lsb_data",      32'(data_l),    32'hF0);
        tick();
        check("bp_final_drain", 32'(valid_m), 32'h0);

        // 24 continuous bits: a valid pulse every 8th cycle, never stalled.
        for (int w = 0; w < 3; w++) begin
            for (int b = 0; b < 8; b++) begin
                d       = words[w][7-b];
                d_valid = 1'b1;
                tick();
                check("stream_d_ready", 32'(d_ready_m), 32'h1);
                if (b == 7) begin
                    check("stream_valid", 32'(valid_m), 32'h1);
                    check("stream_data",  32'(data_m),  32'(words[w]));
                end else begin
                    check("stream_idle", 32'(valid_m), 32'h0);
                end
            end
        end
        d_valid = 1'b0;
        tick();

        // Flush after 5 accepts; the bit presented on the flush edge is dropped.
        send_bits(8'hFF, 5);
        check("fl_cnt5", 32'(cnt_m), 32'h5);
        d = 1'b1; flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fl_cnt0", 32'(cnt_m), 32'h0);
        send_bits(8'hF0, 8);
        d_valid = 1'b0;
        check("fl_data",  32'(data_m),  32'hF0);
        check("fl_valid", 32'(valid_m), 32'h1);
        tick();

        // Flush on the completing accept wins: no word emitted.
        send_bits(8'h55, 7);
        d = 1'b1; flush = 1'b1;
        tick();
        flush = 1'b0; d_valid = 1'b0;
        check("fl_win_valid", 32'(valid_m), 32'h0);
        check("fl_win_cnt",   32'(cnt_m),   32'h0);
        check("fl_win_data",  32'(data_m),  32'hF0);

        // Reset with a held word and 3 bits in flight.
        ready = 1'b0;
        send_bits(8'h5A, 8);
        send_bits(8'hE0, 3);
        d_valid = 1'b0;
        check("rs_pre_valid", 32'(valid_m), 32'h1);
        check("rs_pre_cnt",   32'(cnt_m),   32'h3);
        rst = 1'b1;
        tick();
        check("rs_valid",   32'(valid_m),   32'h0);
        check("rs_data",    32'(data_m),    32'h0);
        check("rs_cnt",     32'(cnt_m),     32'h0);
        check("rs_d_ready", 32'(d_ready_m), 32'h0);
        rst = 1'b0; ready = 1'b1;
        #1;
        check("rs_release_d_ready", 32'(d_ready_m), 32'h1);
        send_bits(8'hC3, 8);
        d_valid = 1'b0;
        check("rs_word_valid", 32'(valid_m), 32'h1);
        check("rs_word_data",  32'(data_m),  32'hC3);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
